// File: rtl/fround_pipe.sv
// Two-stage pipelined IEEE-754 round-to-integral unit with valid/ready flow control.
// S1 classifies and splits the operand; S2 applies the rounding increment and repacks.
module fround_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [1:0]           in_rm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_b,
    output logic                 out_inexact
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned SW   = MAN_W + 1;
    localparam int unsigned BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int unsigned LIM  = BIAS + MAN_W;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RDN = 2'd2;
    localparam logic [1:0] RM_RUP = 2'd3;

    typedef enum logic [1:0] {
        K_PASS  = 2'd0,
        K_SMALL = 2'd1,
        K_NORM  = 2'd2
    } kind_t;

    // Handshake
    logic w_adv1, w_adv2;

    // Stage 1 combinational
    logic             w_s;
    logic [EXP_W-1:0] w_e, w_eeff;
    logic [MAN_W-1:0] w_m;
    logic [SW-1:0]    w_sig, w_unit, w_half, w_trunc;
    logic [31:0]      w_d;
    logic             w_g, w_st;
    kind_t            w_kind;
    logic [W-1:0]     w_pass;

    // Stage 1 registers
    logic             r_v1, r_s1, r_g1, r_st1;
    logic [1:0]       r_rm1;
    kind_t            r_kind1;
    logic [W-1:0]     r_pass1;
    logic [EXP_W-1:0] r_exp1;
    logic [SW-1:0]    r_trunc1, r_unit1;

    // Stage 2 combinational
    logic             w_gs, w_lsb, w_inc, w_inx;
    logic [SW:0]      w_sum;
    logic [W-1:0]     w_res;

    // Stage 2 registers
    logic             r_v2, r_inx2;
    logic [W-1:0]     r_b2;

    assign w_adv2    = out_ready | ~r_v2;
    assign w_adv1    = w_adv2 | ~r_v1;
    assign in_ready  = w_adv1;
    assign out_valid = r_v2;
    assign out_b     = r_b2;
    assign out_inexact = r_inx2;

    // S1: classify and split into truncated significand, rounding unit, guard and sticky
    always_comb begin
        w_s     = in_a[W-1];
        w_e     = in_a[W-2:MAN_W];
        w_m     = in_a[MAN_W-1:0];
        w_eeff  = (w_e == '0) ? EXP_W'(1) : w_e;
        w_sig   = {(w_e != '0), w_m};
        w_kind  = K_PASS;
        w_pass  = in_a;
        w_d     = '0;
        w_unit  = '0;
        w_half  = '0;
        w_trunc = '0;
        w_g     = 1'b0;
        w_st    = 1'b0;
        if (w_e == '1) begin
            if (w_m != '0) begin
                w_pass = in_a | (W'(1) << (MAN_W - 1));
            end
        end else if (w_sig == '0) begin
            w_pass = in_a;
        end else if (32'(w_eeff) >= LIM) begin
            w_pass = in_a;
        end else if (32'(w_eeff) < BIAS) begin
            // |x| < 1: only the half bit and "anything nonzero" matter
            w_kind = K_SMALL;
            w_g    = (32'(w_e) == BIAS - 1);
            w_st   = w_g ? (w_m != '0) : 1'b1;
        end else begin
            w_kind  = K_NORM;
            w_d     = LIM - 32'(w_eeff);
            w_unit  = SW'(1) << w_d;
            w_half  = w_unit >> 1;
            w_g     = |(w_sig & w_half);
            w_st    = |(w_sig & (w_half - SW'(1)));
            w_trunc = w_sig & ~(w_unit - SW'(1));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1     <= 1'b0;
            r_s1     <= 1'b0;
            r_g1     <= 1'b0;
            r_st1    <= 1'b0;
            r_rm1    <= 2'd0;
            r_kind1  <= K_PASS;
            r_pass1  <= '0;
            r_exp1   <= '0;
            r_trunc1 <= '0;
            r_unit1  <= '0;
        end else if (w_adv1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1     <= w_s;
                r_g1     <= w_g;
                r_st1    <= w_st;
                r_rm1    <= in_rm;
                r_kind1  <= w_kind;
                r_pass1  <= w_pass;
                r_exp1   <= w_eeff;
                r_trunc1 <= w_trunc;
                r_unit1  <= w_unit;
            end
        end
    end

    // S2: rounding decision, increment with carry headroom, repack
    always_comb begin
        w_gs  = r_g1 | r_st1;
        w_lsb = |(r_trunc1 & r_unit1);
        case (r_rm1)
            RM_RNE:  w_inc = r_g1 & (r_st1 | w_lsb);
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = r_s1 & w_gs;
            RM_RUP:  w_inc = ~r_s1 & w_gs;
            default: w_inc = 1'b0;
        endcase
        w_sum = {1'b0, r_trunc1} + (w_inc ? {1'b0, r_unit1} : (SW + 1)'(0));
        w_res = r_pass1;
        w_inx = 1'b0;
        case (r_kind1)
            K_SMALL: begin
                w_inx = w_gs;
                w_res = w_inc ? {r_s1, EXP_W'(BIAS), MAN_W'(0)} : {r_s1, (W - 1)'(0)};
            end
            K_NORM: begin
                w_inx = w_gs;
                if (w_sum[SW]) begin
                    w_res = {r_s1, r_exp1 + EXP_W'(1), MAN_W'(0)};
                end else if (w_sum[MAN_W]) begin
                    w_res = {r_s1, r_exp1, w_sum[MAN_W-1:0]};
                end else begin
                    w_res = {r_s1, (W - 1)'(0)};
                end
            end
            default: begin
                w_res = r_pass1;
                w_inx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v2   <= 1'b0;
            r_b2   <= '0;
            r_inx2 <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_b2   <= w_res;
                r_inx2 <= w_inx;
            end
        end
    end

endmodule

// File: tb/tb_fround_pipe.sv
// Scoreboard bench for fround_pipe: single- and double-precision instances,
// expected results from an integer quotient/remainder rounding model.
module tb_fround_pipe;

    typedef struct {
        logic [63:0] b;
        logic        inx;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        in_valid, in_ready, out_valid, out_ready, out_inexact;
    logic [31:0] in_a, out_b;
    logic [1:0]  in_rm;
    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_inexact;
    logic [63:0] d_in_a, d_out_b;
    logic [1:0]  d_in_rm;

    exp_t sq[$];
    exp_t dq[$];
    exp_t s_front, d_front;
    int   total = 0;
    int   bad = 0;
    bit   rand_done;

    fround_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_rm(in_rm), .out_valid(out_valid), .out_ready(out_ready),
        .out_b(out_b), .out_inexact(out_inexact)
    );

    fround_pipe #(.EXP_W(11), .MAN_W(52)) u_dp (
        .clk(clk), .rstn(rstn), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_a(d_in_a), .in_rm(d_in_rm), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_b(d_out_b), .out_inexact(d_out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round x = sig * 2^-k to an integer q with remainder r, then re-encode q
    function automatic void model(input logic [63:0] a, input int ew, input int mw,
                                  input logic [1:0] rm, output logic [63:0] b, output logic inx);
        longint unsigned bias, emax, e, eeff, m, sig, q, r, half, sgn, fr;
        int   sh, k, p;
        logic s, inc;
        bias = (64'd1 << (ew - 1)) - 64'd1;
        emax = (64'd1 << ew) - 64'd1;
        s    = a[ew+mw];
        e    = (a >> mw) & emax;
        m    = a & ((64'd1 << mw) - 64'd1);
        sgn  = 64'(s) << (ew + mw);
        b    = a;
        inx  = 1'b0;
        if (e == emax) begin
            if (m != 0) b = a | (64'd1 << (mw - 1));
            return;
        end
        sig  = ((e != 0) ? (64'd1 << mw) : 64'd0) | m;
        eeff = (e == 0) ? 64'd1 : e;
        sh   = int'(eeff) - int'(bias) - mw;
        if (sig == 0 || sh >= 0) return;
        k = -sh;
        if (k >= 62) begin
            q = 0; r = sig; half = 64'd1 << 62;
        end else begin
            q = sig >> k; r = sig - (q << k); half = 64'd1 << (k - 1);
        end
        case (rm)
            2'd0:    inc = (r > half) || (r == half && q[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = s && (r != 0);
            default: inc = !s && (r != 0);
        endcase
        q   = q + 64'(inc);
        inx = (r != 0);
        if (q == 0) begin
            b = sgn;
        end else begin
            p = 0;
            for (int i = 0; i < 64; i++) if (q[i]) p = i;
            fr = (q << (mw - p)) & ((64'd1 << mw) - 64'd1);
            b  = sgn | ((bias + 64'(p)) << mw) | fr;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [1:0] rm, input logic [31:0] eb, input logic ei);
        exp_t x;
        bit   ok = 1'b0;
        in_valid = 1'b1; in_a = a; in_rm = rm;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL sp_accept_timeout: in_ready stayed 0 for op %h", a);
        end else begin
            x.b = 64'(eb); x.inx = ei;
            sq.push_back(x);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_d(input logic [63:0] a, input logic [1:0] rm, input logic [63:0] eb, input logic ei);
        exp_t x;
        bit   ok = 1'b0;
        d_in_valid = 1'b1; d_in_a = a; d_in_rm = rm;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (d_in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL dp_accept_timeout: in_ready stayed 0 for op %h", a);
        end else begin
            x.b = eb; x.inx = ei;
            dq.push_back(x);
        end
        @(posedge clk); #1;
        d_in_valid = 1'b0;
    endtask

    task automatic send_rand_sp();
        logic [31:0] a;
        logic [1:0]  rm;
        logic [63:0] mb;
        logic        mi;
        a  = $urandom;
        rm = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) a[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        else a[30:23] = 8'($urandom_range(118, 155));
        model(64'(a), 8, 23, rm, mb, mi);
        send(a, rm, mb[31:0], mi);
    endtask

    // Monitors: compare against the queue head whenever a result is presented,
    // pop only on the handshake so a stalled output is rechecked every cycle.
    always @(negedge clk) begin
        if (rstn && out_valid) begin
            total++;
            if (sq.size() == 0) begin
                bad++;
                $display("FAIL sp_spurious: out_b=%h with no pending op", out_b);
            end else begin
                s_front = sq[0];
                if (out_b !== s_front.b[31:0] || out_inexact !== s_front.inx) begin
                    bad++;
                    $display("FAIL sp_result: got b=%h inx=%b want b=%h inx=%b",
                             out_b, out_inexact, s_front.b[31:0], s_front.inx);
                end
                if (out_ready) void'(sq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && d_out_valid) begin
            total++;
            if (dq.size() == 0) begin
                bad++;
                $display("FAIL dp_spurious: out_b=%h with no pending op", d_out_b);
            end else begin
                d_front = dq[0];
                if (d_out_b !== d_front.b || d_out_inexact !== d_front.inx) begin
                    bad++;
                    $display("FAIL dp_result: got b=%h inx=%b want b=%h inx=%b",
                             d_out_b, d_out_inexact, d_front.b, d_front.inx);
                end
                if (d_out_ready) void'(dq.pop_front());
            end
        end
    end

    logic [31:0] dir_a  [18] = '{32'hC0200000, 32'hC0200000, 32'hC0200000,
                                 32'h40200000, 32'h40600000, 32'h3FFFFFFF,
                                 32'hBF000000, 32'hBF000000, 32'h00000001, 32'h00000001,
                                 32'h80000000, 32'h7F800000, 32'h7FA00000, 32'h4B000001,
                                 32'hBE99999A, 32'hBE99999A, 32'h3E99999A, 32'hBF000000};
    logic [1:0]  dir_rm [18] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2,
                                 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd0};
    logic [31:0] dir_b  [18] = '{32'hC0000000, 32'hC0400000, 32'hC0000000,
                                 32'h40000000, 32'h40800000, 32'h40000000,
                                 32'hBF800000, 32'h80000000, 32'h3F800000, 32'h00000000,
                                 32'h80000000, 32'h7F800000, 32'h7FE00000, 32'h4B000001,
                                 32'hBF800000, 32'h80000000, 32'h00000000, 32'h80000000};
    logic        dir_i  [18] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    task automatic drain(input string nm);
        for (int n = 0; n < 300; n++) begin
            if (sq.size() == 0 && dq.size() == 0) break;
            @(negedge clk);
        end
        chk(nm, 64'(sq.size() + dq.size()), 64'd0);
    endtask

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0; in_a = '0; in_rm = '0; out_ready = 1'b1;
        d_in_valid = 1'b0; d_in_a = '0; d_in_rm = '0; d_out_ready = 1'b1;
        rand_done = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_b", 64'(out_b), 64'd0);
        chk("reset_out_inexact", 64'(out_inexact), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk); #1;

        // Latency: visible in the second cycle after the accepting edge's cycle
        send(32'hC0200000, 2'd0, 32'hC0000000, 1'b1);
        @(negedge clk);
        chk("latency_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_cycle2_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) send(dir_a[i], dir_rm[i], dir_b[i], dir_i[i]);
        drain("directed_drain");
        @(posedge clk); #1;

        // Backpressure: 5-op stream, consumer stalls 3 cycles once the pipe is full
        fork
            begin
                for (int i = 0; i < 5; i++) send_rand_sp();
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                chk("bp_in_ready_full", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        @(posedge clk); #1;

        fork
            begin
                for (int i = 0; i < 300; i++) send_rand_sp();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("random_drain");
        @(posedge clk); #1;

        // Asynchronous reset with two ops in flight
        out_ready = 1'b0;
        send(32'h40200000, 2'd0, 32'h40000000, 1'b1);
        send(32'h40600000, 2'd0, 32'h40800000, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_out_valid", 64'(out_valid), 64'd0);
        chk("rst_async_out_b", 64'(out_b), 64'd0);
        sq.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        send(32'hBF000000, 2'd2, 32'hBF800000, 1'b1);
        @(negedge clk);
        chk("rst_after_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("rst_after_cycle2_valid", 64'(out_valid), 64'd1);
        drain("rst_drain");
        @(posedge clk); #1;

        // Double-precision instance
        send_d(64'hC004000000000000, 2'd2, 64'hC008000000000000, 1'b1);
        send_d(64'hC004000000000000, 2'd0, 64'hC000000000000000, 1'b1);
        for (int i = 0; i < 40; i++) begin
            logic [63:0] a, mb;
            logic [1:0]  rm;
            logic        mi;
            a = {$urandom, $urandom};
            rm = 2'($urandom_range(0, 3));
            a[62:52] = 11'($urandom_range(1013, 1085));
            model(a, 11, 52, rm, mb, mi);
            send_d(a, rm, mb, mi);
        end
        drain("dp_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fround_pipe.md
Name: fround_pipe

Overview:
- Parametrised, pipelined IEEE-754 round-to-integral unit; successor to the combinational floor block.
- Supports four rounding modes selected per operation, any exponent/mantissa width, valid/ready flow control and an inexact flag.
- Sits in the FPU execute path beside the other float units and feeds the result/writeback arbiter.

Parameters:
- EXP_W, 8: exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23: stored mantissa (fraction) width; total width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  unit can accept operand this cycle.
- in_a  in  W  operand.
- in_rm  in  2  mode: 00 RNE (nearest-even), 01 RTZ (trunc), 10 RDN (floor), 11 RUP (ceil).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_b  out  W  integral-valued float result.
- out_inexact  out  1  result != operand (never set for NaN/inf).

Behaviour:
- Reset (async on rstn low, released synchronously to clk): both stage valid bits 0; out_valid=0; out_b=0; out_inexact=0. In-flight operations are discarded.
- Pipeline: two registered stages, S1 then S2; out_b/out_inexact/out_valid driven from S2 registers.
- Latency is exactly 2 cycles from the accepting edge to out_valid with out_ready held high. Throughput is 1 per cycle.
- Transfers occur on a rising edge with valid&ready.
- adv2 = out_ready | ~v2; adv1 = adv2 | ~v1; in_ready = adv1. in_ready may combinationally depend on out_ready.
- Stalled stages hold data unchanged. out_b must stay stable while out_valid=1 and out_ready=0.
- Simultaneous output handshake and input acceptance with a full pipe is a legal single-cycle shift.
- S1: unpack s, e, m. Classify: zero (e=0, m=0), subnormal (e=0, m!=0), inf, NaN (e=all ones). Compute:
  - frac_bits = BIAS+MAN_W-e, clamped to [0, MAN_W+1].
  - Integer-part mantissa (hidden bit included).
  - Guard (first dropped bit) and sticky (OR of the rest).
  - Register these with rm.
- S2: increment decision inc:
  - RTZ: 0.
  - RDN: s & (g|st).
  - RUP: ~s & (g|st).
  - RNE: g & (st | lsb). For |x|<1, lsb=0 and the integer part is 0.
- Renormalise after increment: carry out of the hidden bit gives exponent+1, mantissa 0. Compute with one extra bit of width.
- Result encoding for |x|<1 (e<BIAS, including subnormals):
  - inc=1 gives +/-1.0 (e=BIAS, m=0) with the input sign.
  - inc=0 gives +/-0 with the input sign.
  - Examples: floor(-0.3) = -1.0; ceil(-0.3) = -0.0; floor(0.3) = +0.0.
- e >= BIAS+MAN_W: operand already integral. Pass through unchanged, inexact=0.
- Zeros pass with sign preserved.
- Inf passes unchanged.
- NaN: output the quiet NaN with the input sign and payload, fraction MSB forced to 1; inexact=0.
- out_inexact = (g|st) for finite, non-integral operands.
- Exponent arithmetic is unsigned with EXP_W+2 bits, so no wrap for any EXP_W. Overflow to inf is impossible.

Test Plan:
- Mode sweep on -2.5 (0xC0200000), one op per cycle with out_ready=1 -> results 2 cycles later:
  - RNE 0xC0000000.
  - RTZ 0xC0000000.
  - RDN 0xC0400000.
  - RUP 0xC0000000.
  - inexact=1 for all four.
- RNE ties and carry:
  - 2.5 (0x40200000) -> 0x40000000.
  - 3.5 (0x40600000) -> 0x40800000.
  - 0x3FFFFFFF in RUP -> 0x40000000 (carry bumps exponent).
- Small and special values:
  - -0.5 (0xBF000000): RDN -> 0xBF800000; RUP -> 0x80000000.
  - Subnormal 0x00000001: RUP -> 0x3F800000; RDN -> 0x00000000.
  - 0x80000000 -> 0x80000000, inexact=0.
  - 0x7F800000 -> unchanged.
  - NaN 0x7FA00000 -> 0x7FE00000, inexact=0.
  - 0x4B000001 (integral) -> unchanged, inexact=0.
- Backpressure:
  - Stream 5 ops with out_ready low for 3 cycles mid-stream.
  - Required: in_ready drops when both stages are full, out_b is held stable, no op is lost or duplicated, and order is preserved.
- Reset mid-operation:
  - Assert rstn=0 asynchronously with 2 ops in flight.
  - Required: out_valid=0 immediately (before the next edge) and out_b=0; after release, the first new op appears 2 cycles after acceptance.
- Parameter instance EXP_W=11, MAN_W=52 (double), with -2.5 = 0xC004000000000000:
  - RDN -> 0xC008000000000000.
  - RNE -> 0xC000000000000000.
